// File: rtl/nvdla_cacc_pkg.sv
// Shared definitions for the cacc Q-channel power controller.
// Contents:
//   q_state_t   - Q-channel controller state encodings (Q_RUN .. Q_CONT)
//   IDLE_CNT_W  - width of the idle-cycle counter
//   qreqn_of()  - qreqn level associated with each state
package nvdla_cacc_pkg;

    localparam int IDLE_CNT_W = 8;

    typedef enum logic [2:0] {
        Q_RUN     = 3'd0,
        Q_REQ     = 3'd1,
        Q_STOPPED = 3'd2,
        Q_EXIT    = 3'd3,
        Q_DENIED  = 3'd4,
        Q_CONT    = 3'd5
    } q_state_t;

    // qreqn is high only where cacc is (or is returning to) running.
    // Unknown encodings map to 1 so a corrupted state never holds a stop request.
    function automatic logic qreqn_of(input q_state_t s);
        logic r;
        case (s)
            Q_RUN:     r = 1'b1;
            Q_EXIT:    r = 1'b1;
            Q_CONT:    r = 1'b1;
            Q_REQ:     r = 1'b0;
            Q_STOPPED: r = 1'b0;
            Q_DENIED:  r = 1'b0;
            default:   r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/nvdla_sat_cnt.sv
// Parameterised saturating up-counter.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset (count -> 0)
//   clr        - synchronous clear, has priority over inc
//   inc        - increment by one, holds at all-ones
//   cnt        - registered count value
module nvdla_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    import nvdla_cacc_pkg::*;

    logic [W-1:0] cnt_r;

    // Count register: clear wins over increment, increment stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/nvdla_cacc_qctrl.sv
// Q-channel auto power-down controller for cacc.
// Watches upstream/downstream activity; after idle_thresh quiet cycles it asks
// cacc to stop (qreqn low), tracks accept/deny and brings cacc back on activity.
// Ports:
//   nvdla_core_clk, nvdla_core_rstn - clock, async active-low reset
//   qctrl_en       - auto power-down permitted
//   idle_thresh    - idle cycles before a stop request (0 = never request)
//   act_csb, act_mac_a, act_mac_b, act_sdp, sw_wake - activity indications
//   qreqn (out)    - Q-channel request, active-low, registered
//   qacceptn, qdeny - Q-channel response from cacc
//   qstate (out)   - current state encoding
//   cacc_stopped (out) - high only in Q_STOPPED
//   stop_cnt (out) - completed stop handshakes, saturating
module nvdla_cacc_qctrl #(
    parameter int STOP_CNT_W = 16
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic                  qctrl_en,
    input  logic [7:0]            idle_thresh,
    input  logic                  act_csb,
    input  logic                  act_mac_a,
    input  logic                  act_mac_b,
    input  logic                  act_sdp,
    input  logic                  sw_wake,
    output logic                  qreqn,
    input  logic                  qacceptn,
    input  logic                  qdeny,
    output logic [2:0]            qstate,
    output logic                  cacc_stopped,
    output logic [STOP_CNT_W-1:0] stop_cnt
);
    import nvdla_cacc_pkg::*;

    q_state_t              state_r;
    q_state_t              state_nxt_s;
    logic                  wake_pend_r;
    logic                  wake_pend_nxt_s;
    logic                  qreqn_r;
    logic                  stopped_r;
    logic                  act_s;
    logic                  run_go_s;
    logic                  idle_clr_s;
    logic                  idle_inc_s;
    logic                  stop_inc_s;
    logic [IDLE_CNT_W-1:0] idle_cnt_s;

    assign act_s = act_csb | act_mac_a | act_mac_b | act_sdp | sw_wake;

    // The idle counter is compared as-is, so a threshold change takes effect
    // on the very next comparison without disturbing the count.
    assign run_go_s = qctrl_en && (idle_thresh != 8'd0) &&
                      (idle_cnt_s >= idle_thresh) && !act_s && qacceptn;

    // Next-state, wake-pending and counter control decode.
    always_comb begin
        state_nxt_s     = state_r;
        wake_pend_nxt_s = wake_pend_r;
        idle_clr_s      = 1'b0;
        idle_inc_s      = 1'b0;
        stop_inc_s      = 1'b0;
        case (state_r)
            Q_RUN: begin
                if (act_s) begin
                    idle_clr_s = 1'b1;
                end else begin
                    idle_inc_s = 1'b1;
                end
                if (run_go_s) begin
                    state_nxt_s = Q_REQ;
                end else begin
                    state_nxt_s = Q_RUN;
                end
            end
            Q_REQ: begin
                // qreqn is never withdrawn mid-handshake; remember the wake instead.
                if (act_s) begin
                    wake_pend_nxt_s = 1'b1;
                end else begin
                    wake_pend_nxt_s = wake_pend_r;
                end
                // Accept wins over a simultaneous deny.
                if (!qacceptn) begin
                    state_nxt_s = Q_STOPPED;
                    stop_inc_s  = 1'b1;
                end else if (qdeny) begin
                    state_nxt_s = Q_DENIED;
                end else begin
                    state_nxt_s = Q_REQ;
                end
            end
            Q_STOPPED: begin
                if (act_s || wake_pend_r || !qctrl_en) begin
                    state_nxt_s     = Q_EXIT;
                    wake_pend_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = Q_STOPPED;
                end
            end
            Q_EXIT: begin
                if (qacceptn) begin
                    state_nxt_s = Q_RUN;
                    idle_clr_s  = 1'b1;
                end else begin
                    state_nxt_s = Q_EXIT;
                end
            end
            Q_DENIED: begin
                state_nxt_s = Q_CONT;
            end
            Q_CONT: begin
                if (!qdeny) begin
                    state_nxt_s     = Q_RUN;
                    idle_clr_s      = 1'b1;
                    wake_pend_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = Q_CONT;
                end
            end
            default: begin
                // Illegal encoding: raise qreqn and wait for cacc to report running.
                state_nxt_s     = Q_EXIT;
                wake_pend_nxt_s = 1'b0;
            end
        endcase
    end

    // State and registered Q-channel outputs. Reset leaves the block in
    // Q_STOPPED with a pending wake, matching cacc leaving reset stopped.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_r     <= Q_STOPPED;
            wake_pend_r <= 1'b1;
            qreqn_r     <= 1'b0;
            stopped_r   <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            wake_pend_r <= wake_pend_nxt_s;
            qreqn_r     <= qreqn_of(state_nxt_s);
            stopped_r   <= (state_nxt_s == Q_STOPPED);
        end
    end

    nvdla_sat_cnt #(
        .W (IDLE_CNT_W)
    ) u_idle_cnt (
        .clk   (nvdla_core_clk),
        .rst_n (nvdla_core_rstn),
        .clr   (idle_clr_s),
        .inc   (idle_inc_s),
        .cnt   (idle_cnt_s)
    );

    nvdla_sat_cnt #(
        .W (STOP_CNT_W)
    ) u_stop_cnt (
        .clk   (nvdla_core_clk),
        .rst_n (nvdla_core_rstn),
        .clr   (1'b0),
        .inc   (stop_inc_s),
        .cnt   (stop_cnt)
    );

    assign qreqn        = qreqn_r;
    assign qstate       = state_r;
    assign cacc_stopped = stopped_r;

endmodule

// File: tb/tb_nvdla_cacc_qctrl.sv
// Self-checking bench for nvdla_cacc_qctrl. Two instances share all inputs:
// one with the default 16-bit stop counter, one with a 2-bit counter to
// observe saturation.
module tb_nvdla_cacc_qctrl;

    logic        clk;
    logic        rst_n;
    logic        qctrl_en;
    logic [7:0]  idle_thresh;
    logic        act_csb;
    logic        act_mac_a;
    logic        act_mac_b;
    logic        act_sdp;
    logic        sw_wake;
    logic        qacceptn;
    logic        qdeny;
    logic        qreqn;
    logic [2:0]  qstate;
    logic        cacc_stopped;
    logic [15:0] stop_cnt;
    logic        qreqn2;
    logic [2:0]  qstate2;
    logic        cacc_stopped2;
    logic [1:0]  stop_cnt2;

    int n_cmp;
    int n_bad;

    nvdla_cacc_qctrl dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .qctrl_en        (qctrl_en),
        .idle_thresh     (idle_thresh),
        .act_csb         (act_csb),
        .act_mac_a       (act_mac_a),
        .act_mac_b       (act_mac_b),
        .act_sdp         (act_sdp),
        .sw_wake         (sw_wake),
        .qreqn           (qreqn),
        .qacceptn        (qacceptn),
        .qdeny           (qdeny),
        .qstate          (qstate),
        .cacc_stopped    (cacc_stopped),
        .stop_cnt        (stop_cnt)
    );

    nvdla_cacc_qctrl #(.STOP_CNT_W(2)) dut2 (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .qctrl_en        (qctrl_en),
        .idle_thresh     (idle_thresh),
        .act_csb         (act_csb),
        .act_mac_a       (act_mac_a),
        .act_mac_b       (act_mac_b),
        .act_sdp         (act_sdp),
        .sw_wake         (sw_wake),
        .qreqn           (qreqn2),
        .qacceptn        (qacceptn),
        .qdeny           (qdeny),
        .qstate          (qstate2),
        .cacc_stopped    (cacc_stopped2),
        .stop_cnt        (stop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // act bit order: {csb, mac_a, mac_b, sdp, sw_wake}
    typedef struct {
        logic        en;
        logic [7:0]  th;
        logic [4:0]  act;
        logic        qa;
        logic        qd;
        logic [2:0]  st;
        logic        qr;
        logic        stp;
        logic [15:0] sc;
    } vec_t;

    vec_t vecs[39];

    function automatic vec_t mk(input logic en, input logic [7:0] th, input logic [4:0] act,
                                input logic qa, input logic qd, input logic [2:0] st,
                                input logic qr, input logic stp, input logic [15:0] sc);
        vec_t v;
        v.en = en; v.th = th; v.act = act; v.qa = qa; v.qd = qd;
        v.st = st; v.qr = qr; v.stp = stp; v.sc = sc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        qctrl_en    = v.en;
        idle_thresh = v.th;
        {act_csb, act_mac_a, act_mac_b, act_sdp, sw_wake} = v.act;
        qacceptn    = v.qa;
        qdeny       = v.qd;
    endtask

    initial begin
        int n;
        int bad;
        logic [15:0] sat;
        n_cmp = 0;
        n_bad = 0;

        // Reset release with qacceptn low, count to request, accept, wake by sdp
        vecs[0]  = mk(1'b1, 8'd4, 5'b00000, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 16'd0);
        vecs[1]  = mk(1'b1, 8'd4, 5'b00000, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 16'd0);
        vecs[2]  = mk(1'b1, 8'd4, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd0);
        vecs[3]  = mk(1'b1, 8'd4, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd0);
        vecs[4]  = mk(1'b1, 8'd4, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd0);
        vecs[5]  = mk(1'b1, 8'd4, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd0);
        vecs[6]  = mk(1'b1, 8'd4, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd0);
        vecs[7]  = mk(1'b1, 8'd4, 5'b00000, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 16'd0);
        vecs[8]  = mk(1'b1, 8'd4, 5'b00000, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 16'd1);
        vecs[9]  = mk(1'b1, 8'd4, 5'b00000, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 16'd1);
        vecs[10] = mk(1'b1, 8'd4, 5'b00010, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 16'd1);
        vecs[11] = mk(1'b1, 8'd4, 5'b00000, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 16'd1);
        vecs[12] = mk(1'b1, 8'd4, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd1);
        // Deny path: Q_DENIED, Q_CONT held while qdeny, back to run
        vecs[13] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd1);
        vecs[14] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 16'd1);
        vecs[15] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 16'd1);
        vecs[16] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 16'd1);
        vecs[17] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 16'd1);
        vecs[18] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd1);
        // Accept and deny together: accept wins; qctrl_en low exits stop
        vecs[19] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd1);
        vecs[20] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 16'd1);
        vecs[21] = mk(1'b1, 8'd1, 5'b00000, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 16'd2);
        vecs[22] = mk(1'b0, 8'd1, 5'b00000, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 16'd2);
        vecs[23] = mk(1'b0, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd2);
        // Each activity source alone blocks a due request
        vecs[24] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd2);
        vecs[25] = mk(1'b1, 8'd1, 5'b10000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd2);
        vecs[26] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd2);
        vecs[27] = mk(1'b1, 8'd1, 5'b00100, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd2);
        vecs[28] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd2);
        vecs[29] = mk(1'b1, 8'd1, 5'b00001, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd2);
        vecs[30] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd2);
        vecs[31] = mk(1'b1, 8'd1, 5'b01000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd2);
        vecs[32] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd2);
        // qacceptn low blocks a request; qctrl_en falling in Q_REQ is ignored
        vecs[33] = mk(1'b1, 8'd1, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 16'd2);
        vecs[34] = mk(1'b1, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 16'd2);
        vecs[35] = mk(1'b0, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 16'd2);
        vecs[36] = mk(1'b0, 8'd1, 5'b00000, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 16'd3);
        vecs[37] = mk(1'b0, 8'd1, 5'b00000, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 16'd3);
        vecs[38] = mk(1'b0, 8'd1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd3);

        // Reset state
        rst_n = 1'b0;
        drive(vecs[0]);
        #12;
        chk("rst qstate", 32'(qstate), 32'd2);
        chk("rst qreqn", 32'(qreqn), 32'd0);
        chk("rst cacc_stopped", 32'(cacc_stopped), 32'd1);
        chk("rst stop_cnt", 32'(stop_cnt), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 39; i++) begin
            drive(vecs[i]);
            step();
            sat = (vecs[i].sc > 16'd3) ? 16'd3 : vecs[i].sc;
            chk($sformatf("v%0d qstate", i), 32'(qstate), 32'(vecs[i].st));
            chk($sformatf("v%0d qreqn", i), 32'(qreqn), 32'(vecs[i].qr));
            chk($sformatf("v%0d cacc_stopped", i), 32'(cacc_stopped), 32'(vecs[i].stp));
            chk($sformatf("v%0d stop_cnt", i), 32'(stop_cnt), 32'(vecs[i].sc));
            chk($sformatf("v%0d stop_cnt_w2", i), 32'(stop_cnt2), 32'(sat));
        end

        // Wake during Q_REQ held until cacc accepts 20 cycles later
        qctrl_en = 1'b1; idle_thresh = 8'd2; qacceptn = 1'b1; qdeny = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n++;
            if (qstate == 3'd1) break;
        end
        chk("seqA cycles to req", 32'(n), 32'd3);
        act_mac_a = 1'b1;
        step();
        act_mac_a = 1'b0;
        chk("seqA req after act", 32'(qstate), 32'd1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (qreqn !== 1'b0 || qstate !== 3'd1) bad++;
        end
        chk("seqA qreqn held low", 32'(bad), 32'd0);
        qacceptn = 1'b0;
        step();
        chk("seqA stopped qstate", 32'(qstate), 32'd2);
        chk("seqA cacc_stopped", 32'(cacc_stopped), 32'd1);
        chk("seqA stop_cnt", 32'(stop_cnt), 32'd4);
        chk("seqA stop_cnt_w2", 32'(stop_cnt2), 32'd3);
        step();
        chk("seqA exit qstate", 32'(qstate), 32'd3);
        chk("seqA exit qreqn", 32'(qreqn), 32'd1);
        qacceptn = 1'b1;
        step();
        chk("seqA run qstate", 32'(qstate), 32'd0);

        // Requests disabled: threshold 0, then qctrl_en low
        idle_thresh = 8'd0; qctrl_en = 1'b1;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (qreqn !== 1'b1 || qstate !== 3'd0) bad++;
        end
        chk("seqB thresh0 qreqn", 32'(bad), 32'd0);
        idle_thresh = 8'd4; qctrl_en = 1'b0;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (qreqn !== 1'b1 || qstate !== 3'd0) bad++;
        end
        chk("seqB en0 qreqn", 32'(bad), 32'd0);

        // Threshold lowered mid-count acts next cycle without clearing the count
        qctrl_en = 1'b1; idle_thresh = 8'd200; act_csb = 1'b1;
        step();
        act_csb = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("seqC before thresh change", 32'(qstate), 32'd0);
        idle_thresh = 8'd3;
        step();
        chk("seqC req after thresh change", 32'(qstate), 32'd1);
        qacceptn = 1'b0;
        step();
        chk("seqC stopped", 32'(qstate), 32'd2);
        chk("seqC stop_cnt", 32'(stop_cnt), 32'd5);
        chk("seqC stop_cnt_w2 saturated", 32'(stop_cnt2), 32'd3);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst qstate", 32'(qstate), 32'd2);
        chk("async rst stop_cnt", 32'(stop_cnt), 32'd0);
        chk("async rst qreqn", 32'(qreqn), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
